// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state, window and reset constants for the AHB-to-APB bridge.
// Build option APB_PREADY_EN adds APB wait-state support in the controller.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        READ,
        WRITE,
        WRITEP,
        RENABLE,
        WENABLE,
        WENABLEP
    } apb_state_e;

    localparam logic [7:0] WIN0_BASE  = 8'h80;
    localparam logic [7:0] WIN0_LIMIT = 8'h83;
    localparam logic [7:0] WIN1_BASE  = 8'h84;
    localparam logic [7:0] WIN1_LIMIT = 8'h87;
    localparam logic [7:0] WIN2_BASE  = 8'h88;
    localparam logic [7:0] WIN2_LIMIT = 8'h8B;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_WIN0 = 3'b001;
    localparam logic [2:0] SEL_WIN1 = 3'b010;
    localparam logic [2:0] SEL_WIN2 = 3'b100;

    localparam logic [2:0] RST_PSELX   = SEL_NONE;
    localparam logic       RST_PENABLE = 1'b0;
    localparam logic       RST_PWRITE  = 1'b0;
    localparam logic       RST_HREADY  = 1'b1;

    function automatic logic in_window(
        input logic [7:0] hi,
        input logic [7:0] base,
        input logic [7:0] limit
    );
        return (hi >= base) && (hi <= limit);
    endfunction

    // Common exit from IDLE and the single-transfer access phases
    function automatic apb_state_e dispatch(
        input logic v,
        input logic w
    );
        if (!v)
            return IDLE;
        return w ? WWAIT : READ;
    endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// apb_sel_decode: top address byte to one-hot APB peripheral select.
// Three 64 MB windows starting at 0x8000_0000; anything else selects nothing.
module apb_sel_decode
    import apb_bridge_pkg::*;
(
    input  logic [7:0] addr_hi_i,
    output logic [2:0] sel_o
);

    // Window match on the address region byte
    always_comb begin
        sel_o = SEL_NONE;
        unique case (1'b1)
            in_window(addr_hi_i, WIN0_BASE, WIN0_LIMIT): sel_o = SEL_WIN0;
            in_window(addr_hi_i, WIN1_BASE, WIN1_LIMIT): sel_o = SEL_WIN1;
            in_window(addr_hi_i, WIN2_BASE, WIN2_LIMIT): sel_o = SEL_WIN2;
            default:                                     sel_o = SEL_NONE;
        endcase
    end

endmodule

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: APB SETUP/ACCESS sequencer behind the AHB slave interface.
// Define APB_PREADY_EN to add the Pready port and stretch ACCESS phases.
module apb_fsm_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [ADDR_W-1:0] H_addr1,
    input  logic [ADDR_W-1:0] H_addr2,
    input  logic [DATA_W-1:0] H_wdata1,
    input  logic              Hwritereg,
    input  logic [DATA_W-1:0] Prdata,
`ifdef APB_PREADY_EN
    input  logic              Pready,
`endif
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp
);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [2:0]        pselx_q, pselx_d;
    logic [2:0]        sel_dec;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic              hready_q, hready_d;
    logic              stall;

`ifdef APB_PREADY_EN
    logic              in_access;

    assign stall     = ~Pready;
    assign in_access = (state_q == RENABLE) ||
                       (state_q == WENABLE) ||
                       (state_q == WENABLEP);
    assign Hreadyout = hready_q & ~(in_access & ~Pready);
`else
    assign stall     = 1'b0;
    assign Hreadyout = hready_q;
`endif

    assign Hrdata = Prdata;
    assign Hresp  = 2'b00;

    assign Pselx   = pselx_q;
    assign Penable = penable_q;
    assign Pwrite  = pwrite_q;
    assign Paddr   = paddr_q;
    assign Pwdata  = pwdata_q;

    apb_sel_decode u_sel (
        .addr_hi_i (paddr_d[ADDR_W-1 -: 8]),
        .sel_o     (sel_dec)
    );

    // Next-state decision; access phases wait out a low Pready
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = dispatch(valid, Hwrite);
            WWAIT:    state_d = valid ? WRITEP : WRITE;
            READ:     state_d = RENABLE;
            WRITE:    state_d = valid ? WENABLEP : WENABLE;
            WRITEP:   state_d = WENABLEP;
            RENABLE,
            WENABLE: begin
                if (!stall)
                    state_d = dispatch(valid, Hwrite);
            end
            WENABLEP: begin
                if (!stall) begin
                    if (!Hwritereg)
                        state_d = READ;
                    else
                        state_d = valid ? WRITEP : WRITE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // Output values loaded for the state being entered
    always_comb begin
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = 1'b0;
        hready_d  = 1'b1;
        case (state_d)
            READ: begin
                paddr_d  = Haddr;
                pwrite_d = 1'b0;
                hready_d = 1'b0;
            end
            WRITE: begin
                paddr_d  = H_addr1;
                pwdata_d = Hwdata;
                pwrite_d = 1'b1;
            end
            WRITEP: begin
                paddr_d  = H_addr2;
                pwdata_d = H_wdata1;
                pwrite_d = 1'b1;
                hready_d = 1'b0;
            end
            RENABLE,
            WENABLE,
            WENABLEP: penable_d = 1'b1;
            default:  penable_d = 1'b0;
        endcase
    end

    // Select follows the SETUP address and is held through ACCESS
    always_comb begin
        pselx_d = pselx_q;
        case (state_d)
            READ,
            WRITE,
            WRITEP:  pselx_d = sel_dec;
            IDLE,
            WWAIT:   pselx_d = SEL_NONE;
            default: pselx_d = pselx_q;
        endcase
    end

    // State and registered APB/AHB outputs
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pselx_q   <= RST_PSELX;
            penable_q <= RST_PENABLE;
            pwrite_q  <= RST_PWRITE;
            hready_q  <= RST_HREADY;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            hready_q  <= hready_d;
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed-vector bench for apb_fsm_controller.
// Define APB_PREADY_EN to include the wait-state sequence.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        valid;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] H_addr1;
    logic [31:0] H_addr2;
    logic [31:0] H_wdata1;
    logic        Hwritereg;
    logic [31:0] Prdata;
`ifdef APB_PREADY_EN
    logic        Pready;
`endif
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] b_addr [6];
    logic [2:0]  b_sel  [6];
    logic [31:0] w_addr [4];
    logic [31:0] w_data [4];

    always #5 Hclk = ~Hclk;

    apb_fsm_controller #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .H_addr1   (H_addr1),
        .H_addr2   (H_addr2),
        .H_wdata1  (H_wdata1),
        .Hwritereg (Hwritereg),
        .Prdata    (Prdata),
`ifdef APB_PREADY_EN
        .Pready    (Pready),
`endif
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic ctl(
        input string      tag,
        input logic [2:0] sel,
        input logic       pen,
        input logic       hr
    );
        chk({tag, ".pselx"}, 32'(Pselx), 32'(sel));
        chk({tag, ".penable"}, 32'(Penable), 32'(pen));
        chk({tag, ".hready"}, 32'(Hreadyout), 32'(hr));
    endtask

    task automatic xfer(
        input string       tag,
        input logic [31:0] pa,
        input logic [31:0] pd,
        input logic        pw
    );
        chk({tag, ".paddr"}, Paddr, pa);
        chk({tag, ".pwdata"}, Pwdata, pd);
        chk({tag, ".pwrite"}, 32'(Pwrite), 32'(pw));
    endtask

    task automatic rst_vals(input string tag);
        ctl(tag, 3'b000, 1'b0, 1'b1);
        xfer(tag, 32'h0, 32'h0, 1'b0);
        chk({tag, ".hresp"}, 32'(Hresp), 32'h0);
    endtask

    initial begin
        b_addr = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h83FF_FFFF,
                   32'h8400_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
        b_sel  = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000};
        w_addr = '{32'h8400_0000, 32'h8400_0004, 32'h8400_0008, 32'h8400_000C};
        w_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

        Hresetn   = 1'b0;
        valid     = 1'b0;
        Hwrite    = 1'b0;
        Haddr     = '0;
        Hwdata    = '0;
        H_addr1   = '0;
        H_addr2   = '0;
        H_wdata1  = '0;
        Hwritereg = 1'b0;
        Prdata    = '0;
`ifdef APB_PREADY_EN
        Pready    = 1'b1;
`endif
        tick();
        rst_vals("reset");
        Hresetn = 1'b1;
        tick();
        ctl("idle", 3'b000, 1'b0, 1'b1);

        // single read
        valid  = 1'b1;
        Hwrite = 1'b0;
        Haddr  = 32'h8000_0004;
        Prdata = 32'hDEAD_BEEF;
        tick();
        valid = 1'b0;
        ctl("rd.setup", 3'b001, 1'b0, 1'b0);
        xfer("rd.setup", 32'h8000_0004, 32'h0, 1'b0);
        tick();
        ctl("rd.access", 3'b001, 1'b1, 1'b1);
        chk("rd.hrdata", Hrdata, 32'hDEAD_BEEF);
        tick();
        ctl("rd.idle", 3'b000, 1'b0, 1'b1);
        chk("rd.idle.paddr", Paddr, 32'h8000_0004);

        // select window boundaries
        for (int i = 0; i < 6; i++) begin
            valid  = 1'b1;
            Hwrite = 1'b0;
            Haddr  = b_addr[i];
            tick();
            valid = 1'b0;
            ctl($sformatf("win%0d.setup", i), b_sel[i], 1'b0, 1'b0);
            tick();
            ctl($sformatf("win%0d.access", i), b_sel[i], 1'b1, 1'b1);
            tick();
        end

        // single write
        valid  = 1'b1;
        Hwrite = 1'b1;
        Haddr  = 32'h8800_0000;
        tick();
        ctl("wr.wwait", 3'b000, 1'b0, 1'b1);
        valid   = 1'b0;
        H_addr1 = 32'h8800_0000;
        Hwdata  = 32'h1234_5678;
        tick();
        ctl("wr.setup", 3'b100, 1'b0, 1'b1);
        xfer("wr.setup", 32'h8800_0000, 32'h1234_5678, 1'b1);
        tick();
        ctl("wr.access", 3'b100, 1'b1, 1'b1);
        tick();
        ctl("wr.idle", 3'b000, 1'b0, 1'b1);
        chk("wr.idle.pwdata", Pwdata, 32'h1234_5678);

        // four back-to-back writes
        valid  = 1'b1;
        Hwrite = 1'b1;
        Haddr  = w_addr[0];
        tick();
        ctl("b2b.wwait", 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            valid     = 1'b1;
            Hwritereg = 1'b1;
            Haddr     = w_addr[i+1];
            H_addr2   = w_addr[i];
            H_wdata1  = w_data[i];
            tick();
            ctl($sformatf("b2b%0d.setup", i), 3'b010, 1'b0, 1'b0);
            xfer($sformatf("b2b%0d.setup", i), w_addr[i], w_data[i], 1'b1);
            tick();
            ctl($sformatf("b2b%0d.access", i), 3'b010, 1'b1, 1'b1);
        end
        valid   = 1'b0;
        H_addr1 = w_addr[3];
        Hwdata  = w_data[3];
        tick();
        ctl("b2b3.setup", 3'b010, 1'b0, 1'b1);
        xfer("b2b3.setup", w_addr[3], w_data[3], 1'b1);
        tick();
        ctl("b2b3.access", 3'b010, 1'b1, 1'b1);
        tick();
        ctl("b2b.idle", 3'b000, 1'b0, 1'b1);
        chk("b2b.idle.paddr", Paddr, w_addr[3]);
        Hwritereg = 1'b0;

        // write then read, no idle gap
        valid  = 1'b1;
        Hwrite = 1'b1;
        Haddr  = 32'h8000_0000;
        tick();
        ctl("wrd.wwait", 3'b000, 1'b0, 1'b1);
        Hwrite   = 1'b0;
        Haddr    = 32'h8400_0000;
        H_addr2  = 32'h8000_0000;
        H_wdata1 = 32'hCAFE_F00D;
        tick();
        ctl("wrd.wsetup", 3'b001, 1'b0, 1'b0);
        xfer("wrd.wsetup", 32'h8000_0000, 32'hCAFE_F00D, 1'b1);
        tick();
        ctl("wrd.waccess", 3'b001, 1'b1, 1'b1);
        Hwritereg = 1'b0;
        tick();
        ctl("wrd.rsetup", 3'b010, 1'b0, 1'b0);
        xfer("wrd.rsetup", 32'h8400_0000, 32'hCAFE_F00D, 1'b0);
        valid  = 1'b0;
        Prdata = 32'h0BAD_F00D;
        tick();
        ctl("wrd.raccess", 3'b010, 1'b1, 1'b1);
        chk("wrd.hrdata", Hrdata, 32'h0BAD_F00D);
        tick();
        ctl("wrd.idle", 3'b000, 1'b0, 1'b1);

`ifdef APB_PREADY_EN
        // stretched read access
        valid  = 1'b1;
        Hwrite = 1'b0;
        Haddr  = 32'h8000_0008;
        tick();
        valid  = 1'b0;
        Pready = 1'b0;
        ctl("prdy.setup", 3'b001, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            Pready = (k == 3);
            #1;
            ctl($sformatf("prdy.acc%0d", k), 3'b001, 1'b1, (k == 3));
        end
        tick();
        ctl("prdy.idle", 3'b000, 1'b0, 1'b1);
`endif

        // reset in the middle of a read access phase
        valid  = 1'b1;
        Hwrite = 1'b0;
        Haddr  = 32'h8400_0010;
        tick();
        valid = 1'b0;
        tick();
        ctl("rst.pre", 3'b010, 1'b1, 1'b1);
        chk("rst.pre.paddr", Paddr, 32'h8400_0010);
        #4;
        Hresetn = 1'b0;
        #1;
        rst_vals("rst.async");
        tick();
        rst_vals("rst.edge");
        Hresetn = 1'b1;
        valid   = 1'b1;
        Haddr   = 32'h8800_0020;
        tick();
        valid = 1'b0;
        ctl("rst.redispatch", 3'b100, 1'b0, 1'b0);
        chk("rst.redispatch.paddr", Paddr, 32'h8800_0020);
        tick();
        tick();
        ctl("end.idle", 3'b000, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
